pipeline_control_unit: RTL and testbench

Pipeline-register control for the 5-stage pipelined core. Consumes the load-use `stall` request from the hazard detection unit, the EX-stage branch-taken flush and the data-memory ready handshake. Turns them into per-stage write enables, flush/bubble controls, a halt state and saturating performance counters. Sits beside the hazard detection unit in ID; its outputs gate the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.

---
 rtl/pipeline_control_unit.sv | 153 +++++++++++++++
 tb/tb_pipeline_control_unit.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/pipeline_control_unit.sv
// Pipeline-register control: per-stage write enables, flush/bubble controls, halt state and saturating perf counters.
// Enables/flushes are combinational (0 latency); counters, halted and mem_error update on the next rising edge.
module pipeline_control_unit #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken_ex,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             halt_wb,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_bubble,
  output logic             halted,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic [CNT_W-1:0] mem_wait_cycles
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALTED   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [WAIT_W-1:0] wait_next;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0]  mwait_cnt_q, mwait_cnt_d;
  logic              halted_q, halted_d;
  logic              mem_error_q, mem_error_d;
  logic              freeze;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  assign freeze    = dmem_req & ~dmem_ready;
  assign wait_next = wait_cnt_q + WAIT_W'(1);

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    mwait_cnt_d  = mwait_cnt_q;
    halted_d     = halted_q;
    mem_error_d  = mem_error_q;
    pc_write     = 1'b0;
    ifid_write   = 1'b0;
    idex_write   = 1'b0;
    exmem_write  = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;

    case (state_q)
      ST_RUN, ST_MEM_WAIT: begin
        if (halt_wb) begin
          state_d  = ST_HALTED;
          halted_d = 1'b1;
        end else if (freeze) begin
          memwb_bubble = 1'b1;
          mwait_cnt_d  = sat_inc(mwait_cnt_q);
          // The RUN cycle that first sees the freeze counts toward the timeout.
          if (wait_next >= WAIT_LIMIT) begin
            state_d     = ST_HALTED;
            halted_d    = 1'b1;
            mem_error_d = 1'b1;
          end else begin
            state_d    = ST_MEM_WAIT;
            wait_cnt_d = wait_next;
          end
        end else begin
          state_d     = ST_RUN;
          wait_cnt_d  = '0;
          pc_write    = 1'b1;
          ifid_write  = 1'b1;
          idex_write  = 1'b1;
          exmem_write = 1'b1;
          if (branch_taken_ex) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            flush_cnt_d = sat_inc(flush_cnt_q);
          end else if (stall) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_flush  = 1'b1;
            stall_cnt_d = sat_inc(stall_cnt_q);
          end
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    // Reset holds every stage closed and injects NOPs everywhere.
    if (reset) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_write  = 1'b0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      memwb_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      mwait_cnt_q <= '0;
      halted_q    <= 1'b0;
      mem_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      mwait_cnt_q <= mwait_cnt_d;
      halted_q    <= halted_d;
      mem_error_q <= mem_error_d;
    end
  end

  assign halted          = halted_q;
  assign mem_error       = mem_error_q;
  assign stall_cycles    = stall_cnt_q;
  assign flush_events    = flush_cnt_q;
  assign mem_wait_cycles = mwait_cnt_q;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Scoreboard bench for pipeline_control_unit: directed scenarios plus random traffic against a cycle-level behavioural model.
module tb_pipeline_control_unit;
  localparam int CNT_W = 3;
  localparam int TO    = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, stall, branch_taken_ex, dmem_req, dmem_ready, halt_wb;
  logic pc_write, ifid_write, idex_write, exmem_write;
  logic ifid_flush, idex_flush, memwb_bubble, halted, mem_error;
  logic [CNT_W-1:0] stall_cycles, flush_events, mem_wait_cycles;

  pipeline_control_unit #(.CNT_W(CNT_W), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken_ex(branch_taken_ex),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .halt_wb(halt_wb),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
    .exmem_write(exmem_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .memwb_bubble(memwb_bubble), .halted(halted), .mem_error(mem_error),
    .stall_cycles(stall_cycles), .flush_events(flush_events),
    .mem_wait_cycles(mem_wait_cycles)
  );

  typedef struct {
    logic       chk_comb;
    logic [3:0] we;   // {pc, ifid, idex, exmem}
    logic [2:0] fl;   // {ifid_flush, idex_flush, memwb_bubble}
    logic       hlt;
    logic       err;
    int         sc;
    int         fe;
    int         mw;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural model: consecutive-freeze run length plus halt flags and counters.
  int   m_frz_run = 0;
  logic m_halted  = 1'b0;
  logic m_err     = 1'b0;
  int   m_sc = 0, m_fe = 0, m_mw = 0;

  function automatic int sat(input int v);
    return (v >= MAXC) ? MAXC : v + 1;
  endfunction

  task automatic cycle(input logic r, input logic st, input logic br,
                       input logic rq, input logic rd, input logic hw);
    exp_t e;
    logic frz;
    @(posedge clk);
    #1;
    reset = r; stall = st; branch_taken_ex = br;
    dmem_req = rq; dmem_ready = rd; halt_wb = hw;
    frz = rq & ~rd;
    e.hlt = m_halted; e.err = m_err;
    e.sc = m_sc; e.fe = m_fe; e.mw = m_mw;
    e.chk_comb = 1'b1;
    if (r)             begin e.we = 4'b0000; e.fl = 3'b111; end
    else if (m_halted) begin e.we = 4'b0000; e.fl = 3'b000; end
    else if (hw)       begin e.we = 4'b0000; e.fl = 3'b000; e.chk_comb = 1'b0; end
    else if (frz)      begin e.we = 4'b0000; e.fl = 3'b001; end
    else if (br)       begin e.we = 4'b1111; e.fl = 3'b110; end
    else if (st)       begin e.we = 4'b0011; e.fl = 3'b010; end
    else               begin e.we = 4'b1111; e.fl = 3'b000; end
    sb.push_back(e);

    if (r) begin
      m_frz_run = 0; m_halted = 1'b0; m_err = 1'b0; m_sc = 0; m_fe = 0; m_mw = 0;
    end else if (!m_halted) begin
      if (hw) begin
        m_halted = 1'b1;
      end else if (frz) begin
        m_frz_run++;
        m_mw = sat(m_mw);
        if (m_frz_run >= TO) begin m_halted = 1'b1; m_err = 1'b1; end
      end else begin
        m_frz_run = 0;
        if (br) m_fe = sat(m_fe);
        else if (st) m_sc = sat(m_sc);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.chk_comb) begin
        chk("write_enables", {28'd0, pc_write, ifid_write, idex_write, exmem_write}, {28'd0, e.we});
        chk("flush_bubble", {29'd0, ifid_flush, idex_flush, memwb_bubble}, {29'd0, e.fl});
      end
      chk("halted", {31'd0, halted}, {31'd0, e.hlt});
      chk("mem_error", {31'd0, mem_error}, {31'd0, e.err});
      chk("stall_cycles", 32'(stall_cycles), 32'(e.sc));
      chk("flush_events", 32'(flush_events), 32'(e.fe));
      chk("mem_wait_cycles", 32'(mem_wait_cycles), 32'(e.mw));
    end
  end

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken_ex = 1'b0;
    dmem_req = 1'b0; dmem_ready = 1'b0; halt_wb = 1'b0;
    @(posedge clk);

    // Reset, then idle.
    cycle(1, 0, 0, 0, 0, 0);
    repeat (3) cycle(0, 0, 0, 0, 0, 0);
    // Single load-use stall, then stall with branch.
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    // Three freeze cycles with stall held, then ready with stall.
    cycle(1, 0, 0, 0, 0, 0);
    repeat (3) cycle(0, 1, 0, 1, 0, 0);
    cycle(0, 1, 0, 1, 1, 0);
    cycle(0, 0, 0, 0, 0, 0);
    // Zero-wait memory access.
    cycle(0, 0, 1, 1, 1, 0);
    // Timeout: ready held low.
    repeat (TO + 2) cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 1, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    // Saturate stall counter, then halt_wb during a freeze.
    repeat (MAXC + 3) cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 1, 0, 1);
    repeat (4) cycle(0, 1, 1, 1, 0, 1);
    cycle(0, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom % 60) == 0, $urandom % 3 == 0, $urandom % 4 == 0,
            $urandom % 2 == 0, $urandom % 4 == 0, ($urandom % 50) == 0);
    end
    cycle(0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
